// File: rtl/simple_latch.sv
// Clocked bank of WIDTH independent SR storage cells with complementary outputs.
// S=R=1 is resolved by SR_POLICY and reported per bit and via a sticky flag.
module simple_latch #(
    parameter int WIDTH     = 1,
    parameter int SR_POLICY = 0,
    parameter     RESET_Q   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_illegal,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] illegal,
    output logic             illegal_sticky
);

    // A single-bit RESET_Q is replicated across the bank; wider values are used as given.
    localparam logic [WIDTH-1:0] RESET_VAL =
        ($bits(RESET_Q) == 1) ? {WIDTH{RESET_Q[0]}} : WIDTH'(RESET_Q);

    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] conflict_val;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        both = s & r;
        case (SR_POLICY)
            1:       conflict_val = '1;
            2:       conflict_val = '0;
            3:       conflict_val = ~q;
            default: conflict_val = q;
        endcase
        q_next = (~both & (s | (q & ~r))) | (both & conflict_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q              <= RESET_VAL;
            illegal        <= '0;
            illegal_sticky <= 1'b0;
        end else begin
            q              <= q_next;
            illegal        <= both;
            // A new conflict on the same edge as a clear keeps the flag set.
            illegal_sticky <= (illegal_sticky & ~clr_illegal) | (|both);
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_simple_latch.sv
// Bench for simple_latch: four 1-bit instances (one per policy) and two 4-bit
// instances, checked against a per-bit truth-table model after every edge.
module tb_simple_latch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s1 = 1'b0, r1 = 1'b0, clr = 1'b0;
    logic [3:0] s4 = '0, r4 = '0;

    logic [3:0] q1, qb1, il1, st1;
    logic [3:0] q4 [2];
    logic [3:0] qb4 [2];
    logic [3:0] il4 [2];
    logic [1:0] st4;

    int vectors = 0;
    int errors  = 0;

    int         pol1 [4] = '{0, 1, 2, 3};
    int         pol4 [2] = '{3, 5};
    logic [3:0] rst1 = 4'b1010;
    logic [3:0] rst4 [2] = '{4'b1010, 4'b1111};

    logic [3:0] mq1, mil1, mst1;
    logic [3:0] mq4 [2];
    logic [3:0] mil4 [2];
    logic [1:0] mst4;

    always #5 clk = ~clk;

    simple_latch #(.WIDTH(1), .SR_POLICY(0), .RESET_Q(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .clr_illegal(clr),
        .q(q1[0]), .qbar(qb1[0]), .illegal(il1[0]), .illegal_sticky(st1[0]));
    simple_latch #(.WIDTH(1), .SR_POLICY(1), .RESET_Q(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .clr_illegal(clr),
        .q(q1[1]), .qbar(qb1[1]), .illegal(il1[1]), .illegal_sticky(st1[1]));
    simple_latch #(.WIDTH(1), .SR_POLICY(2), .RESET_Q(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .clr_illegal(clr),
        .q(q1[2]), .qbar(qb1[2]), .illegal(il1[2]), .illegal_sticky(st1[2]));
    simple_latch #(.WIDTH(1), .SR_POLICY(3), .RESET_Q(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .clr_illegal(clr),
        .q(q1[3]), .qbar(qb1[3]), .illegal(il1[3]), .illegal_sticky(st1[3]));
    simple_latch #(.WIDTH(4), .SR_POLICY(3), .RESET_Q(4'b1010)) u4 (
        .clk(clk), .rst_n(rst_n), .s(s4), .r(r4), .clr_illegal(clr),
        .q(q4[0]), .qbar(qb4[0]), .illegal(il4[0]), .illegal_sticky(st4[0]));
    simple_latch #(.WIDTH(4), .SR_POLICY(5), .RESET_Q(1'b1)) u5 (
        .clk(clk), .rst_n(rst_n), .s(s4), .r(r4), .clr_illegal(clr),
        .q(q4[1]), .qbar(qb4[1]), .illegal(il4[1]), .illegal_sticky(st4[1]));

    // Truth table per bit: conflict resolved by policy, anything unknown holds.
    function automatic logic [3:0] sr_next(input int pol, input logic [3:0] q,
                                           input logic [3:0] s, input logic [3:0] r);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            if (s[i] && r[i]) begin
                case (pol)
                    1:       n[i] = 1'b1;
                    2:       n[i] = 1'b0;
                    3:       n[i] = ~q[i];
                    default: n[i] = q[i];
                endcase
            end else if (s[i]) n[i] = 1'b1;
            else if (r[i])     n[i] = 1'b0;
            else               n[i] = q[i];
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq1 = rst1; mil1 = '0; mst1 = '0;
        for (int k = 0; k < 2; k++) begin
            mq4[k] = rst4[k]; mil4[k] = '0; mst4[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            mq1[k]  = sr_next(pol1[k], {3'b0, mq1[k]}, {3'b0, s1}, {3'b0, r1}) & 4'b0001 ? 1'b1 : 1'b0;
            mil1[k] = s1 & r1;
            mst1[k] = (mst1[k] & ~clr) | (s1 & r1);
        end
        for (int k = 0; k < 2; k++) begin
            mq4[k]  = sr_next(pol4[k], mq4[k], s4, r4);
            mil4[k] = s4 & r4;
            mst4[k] = (mst4[k] & ~clr) | (|(s4 & r4));
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q1"},   q1,   mq1);
        chk({tag, ".qb1"},  qb1,  ~mq1);
        chk({tag, ".il1"},  il1,  mil1);
        chk({tag, ".st1"},  st1,  mst1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.q4_%0d", tag, k),  q4[k],  mq4[k]);
            chk($sformatf("%s.qb4_%0d", tag, k), qb4[k], ~mq4[k]);
            chk($sformatf("%s.il4_%0d", tag, k), il4[k], mil4[k]);
        end
        chk({tag, ".st4"}, {2'b0, st4}, {2'b0, mst4});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset with s asserted and no clock edge in between.
        #2;
        s1 = 1'b1; s4 = 4'hF;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        chk("reset_q_rep", q4[1], 4'b1111);
        chk("reset_q_vec", q4[0], 4'b1010);
        @(negedge clk);
        rst_n = 1'b1;
        s1 = 1'b0; s4 = '0;

        r1 = 1'b1; r4 = 4'hF;
        tick("clear");
        chk("clear_q", q1, 4'b0000);
        r1 = 1'b0; r4 = '0;
        for (int i = 0; i < 3; i++) tick("hold0");
        chk("hold0_q", q1, 4'b0000);

        s1 = 1'b1;
        tick("set");
        chk("set_q", q1, 4'b1111);
        s1 = 1'b0;
        tick("hold1");
        chk("hold1_q", q1, 4'b1111);

        s1 = 1'b1; r1 = 1'b1;
        tick("conflict");
        chk("policy_q", q1, 4'b0011);
        chk("policy_il", il1, 4'b1111);
        s1 = 1'b0; r1 = 1'b0;
        tick("pulse_end");
        chk("pulse_il", il1, 4'b0000);
        chk("sticky_held", st1, 4'b1111);

        clr = 1'b1;
        tick("clr");
        chk("clr_sticky", st1, 4'b0000);
        s1 = 1'b1; r1 = 1'b1;
        tick("clr_vs_set");
        chk("clr_vs_set_sticky", st1, 4'b1111);
        clr = 1'b0; s1 = 1'b0; r1 = 1'b0;

        // Wide bank from q=0.
        r4 = 4'hF;
        tick("w_clear");
        s4 = 4'b0101; r4 = 4'b0011;
        tick("w_mix");
        chk("w_mix_q_hold", q4[1], 4'b0100);
        chk("w_mix_il", il4[1], 4'b0001);
        chk("w_mix_q_tog", q4[0], 4'b0101);
        s4 = '0; r4 = '0;

        // Reset mid-operation with requests pending.
        s1 = 1'b0; r1 = 1'b1; s4 = 4'b0110; r4 = 4'b0110;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            s1  = 1'($urandom);
            r1  = 1'($urandom);
            s4  = 4'($urandom);
            r4  = 4'($urandom);
            clr = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
